// File: rtl/flash_arb.sv
// Two-requester arbiter in front of a single flash read port, with a boot-only lock,
// round-robin fairness, a busy-cycle watchdog and a saturating timeout counter.
module flash_arb #(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        boot_done,
  input  logic        r0_cycle,
  input  logic [31:0] r0_addr,
  output logic        r0_ack,
  output logic [31:0] r0_data,
  input  logic        r1_cycle,
  input  logic [31:0] r1_addr,
  output logic        r1_ack,
  output logic [31:0] r1_data,
  output logic        fl_cycle,
  output logic [31:0] fl_addr,
  input  logic        fl_ack,
  input  logic [31:0] fl_data,
  output logic [1:0]  grant,
  output logic        timeout_err,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYC - 1);

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        fl_cycle_q, fl_cycle_d;
  logic [31:0] fl_addr_q, fl_addr_d;
  logic [1:0]  grant_q, grant_d;
  logic        r0_ack_q, r0_ack_d;
  logic [31:0] r0_data_q, r0_data_d;
  logic        r1_ack_q, r1_ack_d;
  logic [31:0] r1_data_q, r1_data_d;
  logic        timeout_err_q, timeout_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        pick_r0, pick_r1;
  logic        tmo_hit;
  logic        rsp_fire;
  logic [31:0] rsp_data;

  // r1 wins a contested slot only after boot and only if r0 went last.
  assign pick_r0 = r0_cycle & (~boot_done | ~r1_cycle | last_grant_q);
  assign pick_r1 = ~pick_r0 & r1_cycle & boot_done;

  // A real ack always beats a watchdog expiry on the same edge.
  assign tmo_hit  = (state_q == BUSY) & ~fl_ack & (tmo_cnt_q == TmoLast);
  assign rsp_fire = (state_q == BUSY) & (fl_ack | tmo_hit);
  assign rsp_data = fl_ack ? fl_data : ERR_DATA;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    tmo_cnt_d     = tmo_cnt_q;
    fl_cycle_d    = fl_cycle_q;
    fl_addr_d     = fl_addr_q;
    grant_d       = grant_q;
    r0_ack_d      = 1'b0;
    r0_data_d     = r0_data_q;
    r1_ack_d      = 1'b0;
    r1_data_d     = r1_data_q;
    timeout_err_d = 1'b0;
    err_cnt_d     = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (pick_r0 || pick_r1) begin
          grant_d      = pick_r0 ? 2'b01 : 2'b10;
          fl_addr_d    = pick_r0 ? r0_addr : r1_addr;
          fl_cycle_d   = 1'b1;
          last_grant_d = pick_r1;
          tmo_cnt_d    = 16'd0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (rsp_fire) begin
          fl_cycle_d = 1'b0;
          state_d    = RELEASE;
          if (grant_q[0]) begin
            r0_ack_d  = 1'b1;
            r0_data_d = rsp_data;
          end
          if (grant_q[1]) begin
            r1_ack_d  = 1'b1;
            r1_data_d = rsp_data;
          end
          if (tmo_hit) begin
            timeout_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      RELEASE: begin
        // Lets the requester's dropped cycle be seen before the next arbitration.
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        grant_d    = 2'b00;
        fl_cycle_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      tmo_cnt_q     <= 16'd0;
      fl_cycle_q    <= 1'b0;
      fl_addr_q     <= 32'd0;
      grant_q       <= 2'b00;
      r0_ack_q      <= 1'b0;
      r0_data_q     <= 32'd0;
      r1_ack_q      <= 1'b0;
      r1_data_q     <= 32'd0;
      timeout_err_q <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      tmo_cnt_q     <= tmo_cnt_d;
      fl_cycle_q    <= fl_cycle_d;
      fl_addr_q     <= fl_addr_d;
      grant_q       <= grant_d;
      r0_ack_q      <= r0_ack_d;
      r0_data_q     <= r0_data_d;
      r1_ack_q      <= r1_ack_d;
      r1_data_q     <= r1_data_d;
      timeout_err_q <= timeout_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign fl_cycle    = fl_cycle_q;
  assign fl_addr     = fl_addr_q;
  assign grant       = grant_q;
  assign r0_ack      = r0_ack_q;
  assign r0_data     = r0_data_q;
  assign r1_ack      = r1_ack_q;
  assign r1_data     = r1_data_q;
  assign timeout_err = timeout_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_flash_arb.sv
// Scenario bench for flash_arb: directed boot/timeout/collision/reset cases plus randomized
// traffic checked against a transaction-level model of arbitration and completion.
module tb_flash_arb;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        sys_clk = 1'b0;
  logic        sys_rst, boot_done;
  logic        r0_cycle, r1_cycle, fl_ack;
  logic [31:0] r0_addr, r1_addr, fl_data;
  logic        r0_ack, r1_ack, fl_cycle, timeout_err;
  logic [31:0] r0_data, r1_data, fl_addr;
  logic [1:0]  grant;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  // Model state: who went last, error count, each requester's last delivered word.
  logic        m_last;
  logic [7:0]  m_err;
  logic [31:0] m_d0, m_d1;

  always #5 sys_clk = ~sys_clk;

  flash_arb #(.TIMEOUT_CYC(TO), .ERR_DATA(ERR)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .boot_done   (boot_done),
    .r0_cycle    (r0_cycle),
    .r0_addr     (r0_addr),
    .r0_ack      (r0_ack),
    .r0_data     (r0_data),
    .r1_cycle    (r1_cycle),
    .r1_addr     (r1_addr),
    .r1_ack      (r1_ack),
    .r1_data     (r1_data),
    .fl_cycle    (fl_cycle),
    .fl_addr     (fl_addr),
    .fl_ack      (fl_ack),
    .fl_data     (fl_data),
    .grant       (grant),
    .timeout_err (timeout_err),
    .err_cnt     (err_cnt)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Flash responds in BUSY cycle lat (1-based); lat > TO means no response at all.
  // Requester inputs are scrambled meanwhile; busy_addr is fl_addr in the last BUSY cycle.
  task automatic busy_phase(input int lat, input logic [31:0] d, output logic [31:0] busy_addr);
    busy_addr = fl_addr;
    for (int c = 1; c <= int'(TO); c++) begin
      busy_addr = fl_addr;
      r0_addr   = $urandom;
      r1_addr   = $urandom;
      r0_cycle  = 1'($urandom_range(0, 1));
      r1_cycle  = 1'($urandom_range(0, 1));
      boot_done = 1'($urandom_range(0, 1));
      fl_ack    = (c == lat);
      fl_data   = (c == lat) ? d : $urandom;
      tick();
      if (c == lat) break;
    end
    fl_ack = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; boot_done = 1'b0; r0_cycle = 1'b0; r1_cycle = 1'b0;
    r0_addr = 32'h0; r1_addr = 32'h0; fl_ack = 1'b0; fl_data = 32'h0;
    tick();
    tick();
    total++;
    if ({fl_cycle, grant, r0_ack, r1_ack, timeout_err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000", {fl_cycle, grant, r0_ack, r1_ack, timeout_err});
    end
    total++;
    if (fl_addr !== 32'h0) begin
      bad++; $display("FAIL reset_fl_addr got=%h exp=0", fl_addr);
    end
    total++;
    if ({r0_data, r1_data} !== 64'h0) begin
      bad++; $display("FAIL reset_data got=%h/%h exp=0/0", r0_data, r1_data);
    end
    total++;
    if (err_cnt !== 8'h00) begin
      bad++; $display("FAIL reset_err_cnt got=%h exp=00", err_cnt);
    end
    sys_rst = 1'b0;
    tick();
    total++;
    if ({grant, fl_cycle} !== 3'b000) begin
      bad++; $display("FAIL reset_idle got=%b exp=000", {grant, fl_cycle});
    end
    m_last = 1'b1; m_err = 8'h00; m_d0 = 32'h0; m_d1 = 32'h0;
  endtask

  task automatic test_boot_lock();
    logic seen_r1;
    boot_done = 1'b0; r0_cycle = 1'b1; r1_cycle = 1'b1;
    r0_addr = 32'h0000_0004; r1_addr = 32'h0000_0100;
    tick();
    total++;
    if (grant !== 2'b01 || fl_cycle !== 1'b1 || fl_addr !== 32'h4) begin
      bad++;
      $display("FAIL boot_grant got=%b/%b/%h exp=01/1/00000004", grant, fl_cycle, fl_addr);
    end
    m_last = 1'b0;
    fl_ack = 1'b0;
    tick();
    tick();
    fl_ack = 1'b1; fl_data = 32'h1234_5678;
    tick();
    fl_ack = 1'b0;
    total++;
    if (r0_ack !== 1'b1 || r0_data !== 32'h1234_5678 || r1_ack !== 1'b0) begin
      bad++;
      $display("FAIL boot_ack got=%b/%h/%b exp=1/12345678/0", r0_ack, r0_data, r1_ack);
    end
    total++;
    if (fl_cycle !== 1'b0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL boot_done_state got=%b/%b exp=0/0", fl_cycle, timeout_err);
    end
    m_d0 = 32'h1234_5678;
    r0_cycle = 1'b0;
    seen_r1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (grant[1] === 1'b1 || r1_ack === 1'b1) seen_r1 = 1'b1;
    end
    total++;
    if (seen_r1 !== 1'b0 || grant !== 2'b00) begin
      bad++; $display("FAIL boot_lock_r1 got=%b/%b exp=0/00", seen_r1, grant);
    end
    r1_cycle = 1'b0;
  endtask

  task automatic test_round_robin(input int n);
    logic        owner;
    logic [1:0]  exp_g;
    logic [31:0] a0, a1, d, exp_a, baddr;
    for (int i = 0; i < n; i++) begin
      owner = ~m_last;
      exp_g = owner ? 2'b10 : 2'b01;
      a0 = $urandom; a1 = $urandom;
      boot_done = 1'b1; r0_cycle = 1'b1; r1_cycle = 1'b1; r0_addr = a0; r1_addr = a1;
      exp_a = owner ? a1 : a0;
      tick();
      total++;
      if (grant !== exp_g || fl_cycle !== 1'b1 || fl_addr !== exp_a) begin
        bad++;
        $display("FAIL rr_grant[%0d] got=%b/%b/%h exp=%b/1/%h", i, grant, fl_cycle, fl_addr,
                 exp_g, exp_a);
      end
      d = $urandom;
      busy_phase($urandom_range(1, TO), d, baddr);
      if (owner) m_d1 = d; else m_d0 = d;
      total++;
      if (baddr !== exp_a) begin
        bad++; $display("FAIL rr_addr_stable[%0d] got=%h exp=%h", i, baddr, exp_a);
      end
      total++;
      if ({r1_ack, r0_ack} !== exp_g || {r0_data, r1_data} !== {m_d0, m_d1}) begin
        bad++;
        $display("FAIL rr_ack[%0d] got=%b/%h/%h exp=%b/%h/%h", i, {r1_ack, r0_ack}, r0_data,
                 r1_data, exp_g, m_d0, m_d1);
      end
      total++;
      if (fl_cycle !== 1'b0 || grant !== exp_g || timeout_err !== 1'b0) begin
        bad++;
        $display("FAIL rr_release[%0d] got=%b/%b/%b exp=0/%b/0", i, fl_cycle, grant, timeout_err,
                 exp_g);
      end
      m_last = owner;
      tick();
      total++;
      if (grant !== 2'b00 || {r1_ack, r0_ack} !== 2'b00) begin
        bad++; $display("FAIL rr_idle[%0d] got=%b/%b exp=00/00", i, grant, {r1_ack, r0_ack});
      end
    end
    r0_cycle = 1'b0; r1_cycle = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt;
    boot_done = 1'b1; r0_cycle = 1'b0; r1_cycle = 1'b1; r1_addr = $urandom; fl_ack = 1'b0;
    tick();
    total++;
    if (grant !== 2'b10) begin
      bad++; $display("FAIL tmo_grant got=%b exp=10", grant);
    end
    m_last = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10 && r1_ack !== 1'b1; i++) begin
      if (fl_cycle === 1'b1) cnt++;
      r1_addr = $urandom;
      tick();
    end
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
    m_d1 = ERR;
    total++;
    if (r1_ack !== 1'b1 || cnt != int'(TO)) begin
      bad++; $display("FAIL tmo_busy_len got=ack%b/%0d exp=ack1/%0d", r1_ack, cnt, TO);
    end
    total++;
    if (r1_data !== ERR || timeout_err !== 1'b1 || err_cnt !== m_err || r0_ack !== 1'b0) begin
      bad++;
      $display("FAIL tmo_result got=%h/%b/%h/%b exp=%h/1/%h/0", r1_data, timeout_err, err_cnt,
               r0_ack, ERR, m_err);
    end
    r1_cycle = 1'b0;
    tick();
    total++;
    if (timeout_err !== 1'b0 || r1_ack !== 1'b0) begin
      bad++; $display("FAIL tmo_pulse got=%b/%b exp=0/0", timeout_err, r1_ack);
    end
  endtask

  task automatic test_collision();
    logic [31:0] baddr;
    r0_cycle = 1'b1; r1_cycle = 1'b0; r0_addr = $urandom;
    tick();
    total++;
    if (grant !== 2'b01) begin
      bad++; $display("FAIL coll_grant got=%b exp=01", grant);
    end
    m_last = 1'b0;
    busy_phase(TO, 32'hA5A5_A5A5, baddr);
    m_d0 = 32'hA5A5_A5A5;
    total++;
    if (r0_ack !== 1'b1 || r0_data !== 32'hA5A5_A5A5 || timeout_err !== 1'b0 ||
        err_cnt !== m_err) begin
      bad++;
      $display("FAIL coll_result got=%b/%h/%b/%h exp=1/a5a5a5a5/0/%h", r0_ack, r0_data,
               timeout_err, err_cnt, m_err);
    end
    r0_cycle = 1'b0; r1_cycle = 1'b0;
    tick();
  endtask

  task automatic test_random_mix(input int n);
    logic        c0, c1, b, g0, g1, to;
    logic [1:0]  exp_g;
    logic [31:0] a0, a1, d, exp_d, baddr;
    int          lat;
    for (int i = 0; i < n; i++) begin
      c0 = 1'($urandom_range(0, 1)); c1 = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
      a0 = $urandom; a1 = $urandom;
      r0_cycle = c0; r1_cycle = c1; boot_done = b; r0_addr = a0; r1_addr = a1;
      g0 = c0 && (!b || !c1 || m_last);
      g1 = !g0 && c1 && b;
      exp_g = {g1, g0};
      tick();
      total++;
      if (grant !== exp_g || fl_cycle !== (g0 | g1)) begin
        bad++;
        $display("FAIL mix_grant[%0d] got=%b/%b exp=%b/%b", i, grant, fl_cycle, exp_g, g0 | g1);
      end
      if (g0 || g1) begin
        total++;
        if (fl_addr !== (g0 ? a0 : a1)) begin
          bad++; $display("FAIL mix_addr[%0d] got=%h exp=%h", i, fl_addr, g0 ? a0 : a1);
        end
        lat = $urandom_range(1, TO + 2);
        d = $urandom;
        busy_phase(lat, d, baddr);
        to = (lat > int'(TO));
        exp_d = to ? ERR : d;
        if (g0) m_d0 = exp_d; else m_d1 = exp_d;
        if (to && m_err != 8'hFF) m_err = m_err + 8'd1;
        m_last = g1;
        total++;
        if ({r1_ack, r0_ack} !== exp_g || {r0_data, r1_data} !== {m_d0, m_d1} ||
            timeout_err !== to || err_cnt !== m_err) begin
          bad++;
          $display("FAIL mix_done[%0d] got=%b/%h/%h/%b/%h exp=%b/%h/%h/%b/%h", i,
                   {r1_ack, r0_ack}, r0_data, r1_data, timeout_err, err_cnt,
                   exp_g, m_d0, m_d1, to, m_err);
        end
        r0_cycle = 1'b0; r1_cycle = 1'b0;
        tick();
      end
    end
    r0_cycle = 1'b0; r1_cycle = 1'b0;
  endtask

  task automatic test_spurious_ack();
    logic [31:0] d, baddr;
    r0_cycle = 1'b0; r1_cycle = 1'b0; fl_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fl_data = $urandom;
      tick();
      total++;
      if ({r1_ack, r0_ack, fl_cycle, grant} !== 5'b0 || {r0_data, r1_data} !== {m_d0, m_d1}) begin
        bad++;
        $display("FAIL spur_idle[%0d] got=%b/%h/%h exp=00000/%h/%h", i,
                 {r1_ack, r0_ack, fl_cycle, grant}, r0_data, r1_data, m_d0, m_d1);
      end
    end
    fl_ack = 1'b0; r0_cycle = 1'b1; boot_done = 1'b0;
    tick();
    m_last = 1'b0;
    d = $urandom;
    busy_phase(1, d, baddr);
    m_d0 = d;
    total++;
    if (r0_ack !== 1'b1 || r0_data !== d) begin
      bad++; $display("FAIL spur_txn got=%b/%h exp=1/%h", r0_ack, r0_data, d);
    end
    r0_cycle = 1'b0; r1_cycle = 1'b0;
    fl_ack = 1'b1; fl_data = ~d;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({r1_ack, r0_ack} !== 2'b00 || r0_data !== d || fl_cycle !== 1'b0) begin
        bad++;
        $display("FAIL spur_release[%0d] got=%b/%h/%b exp=00/%h/0", i, {r1_ack, r0_ack}, r0_data,
                 fl_cycle, d);
      end
    end
    fl_ack = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    r0_cycle = 1'b1; r1_cycle = 1'b0; r0_addr = $urandom;
    tick();
    tick();
    sys_rst = 1'b1; r0_cycle = 1'b0;
    tick();
    sys_rst = 1'b0; fl_ack = 1'b1; fl_data = $urandom;
    tick();
    tick();
    fl_ack = 1'b0;
    m_last = 1'b1; m_err = 8'h00; m_d0 = 32'h0; m_d1 = 32'h0;
    total++;
    if ({fl_cycle, grant, r0_ack, r1_ack, timeout_err} !== 6'b0 || fl_addr !== 32'h0) begin
      bad++;
      $display("FAIL rst_busy_ctrl got=%b/%h exp=000000/0",
               {fl_cycle, grant, r0_ack, r1_ack, timeout_err}, fl_addr);
    end
    total++;
    if ({r0_data, r1_data} !== 64'h0 || err_cnt !== 8'h00) begin
      bad++; $display("FAIL rst_busy_data got=%h/%h/%h exp=0/0/0", r0_data, r1_data, err_cnt);
    end
  endtask

  task automatic test_err_saturation();
    int seen;
    seen = 0;
    boot_done = 1'b1; r1_cycle = 1'b0; fl_ack = 1'b0;
    for (int i = 0; i < 300; i++) begin
      r0_cycle = 1'b1; r0_addr = $urandom;
      tick();
      for (int c = 0; c < int'(TO); c++) tick();
      if (timeout_err === 1'b1 && r0_ack === 1'b1) seen++;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      r0_cycle = 1'b0;
      tick();
    end
    m_last = 1'b0; m_d0 = ERR;
    total++;
    if (err_cnt !== 8'hFF || err_cnt !== m_err) begin
      bad++; $display("FAIL sat_err_cnt got=%h exp=ff", err_cnt);
    end
    total++;
    if (seen != 300 || r0_data !== ERR) begin
      bad++; $display("FAIL sat_timeouts got=%0d/%h exp=300/%h", seen, r0_data, ERR);
    end
  endtask

  initial begin
    test_reset();
    test_boot_lock();
    test_round_robin(12);
    test_timeout();
    test_collision();
    test_random_mix(60);
    test_spurious_ack();
    test_reset_mid_busy();
    test_err_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flash_arb.md
FLASH_ARB -- requirements
Module: flash_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 256, is the number of flash-busy cycles without fl_ack before abort; the legal range is 2..65535.
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF, is the read data returned on timeout.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, as specified in REQ-004 and REQ-005.
REQ-004 sys_clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 sys_rst  in  1  synchronous, active-high reset.
REQ-006 boot_done  in  1  when low, only requester 0 (boot loader) may be granted.
REQ-007 r0_cycle  in  1  requester 0 read request, held until r0_ack.
REQ-008 r0_addr  in  32  requester 0 byte address.
REQ-009 r0_ack  out  1  requester 0 completion pulse.
REQ-010 r0_data  out  32  requester 0 read data, valid while r0_ack=1.
REQ-011 r1_cycle, r1_addr, r1_ack, r1_data  same as REQ-007..010, for requester 1 (runtime host).
REQ-012 fl_cycle  out  1  request to the flash controller.
REQ-013 fl_addr  out  32  address to the flash controller.
REQ-014 fl_ack  in  1  flash controller completion strobe.
REQ-015 fl_data  in  32  flash read data, valid with fl_ack.
REQ-016 grant  out  2  one-hot owner of the flash port: bit0 is r0, bit1 is r1, 00 is none.
REQ-017 timeout_err  out  1  one-cycle pulse on abort.
REQ-018 err_cnt  out  8  saturating count of timeouts.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUSY, RELEASE.
REQ-020 IDLE arbitration, evaluated on each edge:
- r0 is granted if r0_cycle=1 and (boot_done=0, or r1_cycle=0, or last_grant=1).
- Otherwise r1 is granted if r1_cycle=1 and boot_done=1.
- Otherwise the FSM stays in IDLE.
REQ-021 last_grant SHALL be a 1-bit register holding the index of the last granted requester, updated on every grant.
REQ-022 On a grant edge the block SHALL, in the same edge:
- register grant, fl_cycle=1, and fl_addr = the selected requester's address;
- clear the timeout counter;
- enter BUSY.
fl_cycle is therefore high in the cycle after the request is sampled.
REQ-023 fl_addr SHALL remain stable throughout BUSY, even if the requester's address changes.
REQ-024 In BUSY, when fl_ack=1 at an edge, the block SHALL:
- drive the granted requester's ack=1 and data=fl_data for exactly one cycle;
- set fl_cycle=0;
- enter RELEASE.
REQ-025 In BUSY with fl_ack=0, the 16-bit timeout counter SHALL increment by 1 each cycle.
REQ-026 A timeout occurs when the counter equals TIMEOUT_CYC-1 and fl_ack=0 at an edge. The block SHALL then:
- set fl_cycle=0;
- drive the granted requester's ack=1 and data=ERR_DATA for one cycle;
- pulse timeout_err=1 for one cycle;
- increment err_cnt, saturating at 8'hFF;
- enter RELEASE.
REQ-027 If fl_ack=1 on the same edge the timeout would fire, normal completion SHALL take priority and no error is recorded.
REQ-028 RELEASE SHALL last exactly one cycle with fl_cycle=0, grant retained and both acks 0, then return to IDLE. This guarantees the requester's deasserted cycle is sampled before re-arbitration.
REQ-029 grant SHALL return to 00 on entry to IDLE.
REQ-030 A requester dropping its cycle while in BUSY SHALL NOT abort the transaction; completion (or timeout) and its ack still occur.
REQ-031 fl_ack asserted in IDLE or RELEASE SHALL be ignored: no ack, no data, no state change.
REQ-032 The non-granted requester's ack SHALL be 0 at all times, and its data SHALL hold its last value.
REQ-033 boot_done falling while r1 is in BUSY SHALL NOT abort that transaction; the boot-only lock applies from the next IDLE arbitration.
REQ-034 r0_data and r1_data SHALL update only on that requester's ack edge.
REQ-035 There SHALL be no combinational path from any input to any output; all outputs are registered.

Reset
REQ-036 On sys_rst=1 at an edge, the block SHALL set:
- state=IDLE, fl_cycle=0, fl_addr=0, grant=00;
- r0_ack=r1_ack=0, r0_data=r1_data=0;
- timeout_err=0, err_cnt=0, counter=0, last_grant=1.
REQ-037 Reset asserted during BUSY SHALL abandon the transaction with no ack to either requester; any fl_ack arriving after reset is ignored per REQ-031.

Verification
REQ-038 Boot lock: boot_done=0, r0_cycle=r1_cycle=1, r0_addr=32'h0000_0004, fl_ack after 3 cycles with fl_data=32'h1234_5678 -> grant=01, fl_addr=32'h4, r0_ack pulse with r0_data=32'h1234_5678; r1 is never granted while boot_done=0.
REQ-039 Round-robin: boot_done=1, both requesters continuously requesting, flash acking every transfer after 1 cycle -> grants alternate 01,10,01,10; one RELEASE cycle separates each pair of consecutive fl_cycle pulses.
REQ-040 Timeout: TIMEOUT_CYC=4, r1 granted, fl_ack never asserted -> fl_cycle drops after 4 BUSY cycles; r1_ack=1 with r1_data=32'hDEAD_BEEF; timeout_err pulses once; err_cnt=1.
REQ-041 Ack/timeout collision: TIMEOUT_CYC=4, fl_ack=1 on the 4th BUSY cycle with fl_data=32'hA5A5_A5A5 -> r0_data=32'hA5A5_A5A5, timeout_err=0, err_cnt unchanged.
REQ-042 Spurious and reset cases:
- fl_ack pulsed in IDLE -> no ack on either requester.
- sys_rst in mid-BUSY, then fl_ack -> all outputs at reset values and no ack.
- 300 forced timeouts -> err_cnt=8'hFF.
